instruction_fetch_unit: RTL and testbench

//  PC and fetch stage of the SDLX core, directly upstream of the instruction memory.

---
 rtl/sdlx_pkg.sv | 15 +
 rtl/if_id_reg.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sdlx_pkg.sv
// Shared SDLX core types and constants for the fetch stage and instruction memory.
package sdlx_pkg;

  localparam int unsigned AW_DEFAULT = 32;
  localparam int unsigned DW_DEFAULT = 32;

  localparam logic [31:0] SDLX_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, flush (kill valid), load (capture fetch), else hold.
module if_id_reg
  import sdlx_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          flush,
  input  logic [DW-1:0] instr_d,
  input  logic [AW-1:0] pc_d,
  output logic          valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next
);

  // Flush only drops valid; payload keeps its last captured value so no X ever enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      instr   <= DW'(SDLX_NOP);
      pc      <= '0;
      pc_next <= '0;
    end else if (flush) begin
      valid   <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_d;
      pc      <= pc_d;
      pc_next <= pc_d + AW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// SDLX fetch stage: PC register, boot/run/fault control, redirect/stall handling, IF/ID capture.
module instruction_fetch_unit
  import sdlx_pkg::*;
#(
  parameter int unsigned   AW         = AW_DEFAULT,
  parameter int unsigned   DW         = DW_DEFAULT,
  parameter int unsigned   IMEM_DEPTH = 32,
  parameter logic [AW-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_next,
  output logic          fetch_fault
);

  localparam logic [AW-1:0] DEPTH_A = AW'(IMEM_DEPTH);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic          fault_q;

  logic          pc_in_range_c;
  logic          redir_in_range_c;
  logic          load_c;
  logic          flush_c;

  assign pc_in_range_c    = (pc_q < DEPTH_A);
  assign redir_in_range_c = (redirect_pc < DEPTH_A);
  assign imem_addr        = pc_q;
  assign fetch_fault      = fault_q;

  // PC and fetch state; redirect beats stall, and the wrapped PC is range-checked like any other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          if (redirect_valid) pc_q <= redirect_pc;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (!stall) begin
            if (pc_in_range_c) begin
              pc_q <= pc_q + AW'(1);
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (redir_in_range_c) begin
              state_q <= RUN;
              fault_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= BOOT;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID control: capture only on an in-range, unstalled, unredirected RUN cycle.
  always_comb begin
    load_c  = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
        end else if (!stall) begin
          if (pc_in_range_c) load_c  = 1'b1;
          else               flush_c = 1'b1;
        end
      end
      default: flush_c = 1'b1;
    endcase
  end

  if_id_reg #(
    .AW (AW),
    .DW (DW)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .flush   (flush_c),
    .instr_d (imem_rdata),
    .pc_d    (pc_q),
    .valid   (id_valid),
    .instr   (id_instr),
    .pc      (id_pc),
    .pc_next (id_pc_next)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Vector-table bench for instruction_fetch_unit with a per-cycle expected-result scoreboard.
module tb_instruction_fetch_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc_next;
  logic          fetch_fault;

  always #5 clk = ~clk;

  logic [DW-1:0] imem [DEPTH];
  assign imem_rdata = (imem_addr < DEPTH) ? imem[imem_addr[4:0]] : 32'hBAD0_0000;

  instruction_fetch_unit #(
    .AW         (AW),
    .DW         (DW),
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_next     (id_pc_next),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    string         name;
    logic          rst;
    logic          stl;
    logic          rv;
    logic [AW-1:0] rpc;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] e_pcn;
    logic          e_fault;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic void add(string name, logic rst, logic stl, logic rv, logic [AW-1:0] rpc,
                              logic [AW-1:0] e_addr, logic e_valid, logic [DW-1:0] e_instr,
                              logic [AW-1:0] e_pc, logic [AW-1:0] e_pcn, logic e_fault);
    vec_t v;
    v.name = name; v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_pcn = e_pcn; v.e_fault = e_fault;
    vecs.push_back(v);
  endfunction

  // Plain fetch of word p (imem[p] = p): captured on id_*, PC advances to p+1.
  function automatic void run(logic [AW-1:0] p);
    add("run", 1'b0, 1'b0, 1'b0, '0, p + 1, 1'b1, p, p, p + 1, 1'b0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t e;
    for (int i = 0; i < DEPTH; i++) imem[i] = DW'(i);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset then boot bubble, then words 0..3.
    for (int i = 0; i < 5; i++) add("reset", 1, 0, 0, '0, '0, 0, '0, '0, '0, 0);
    add("boot_bubble", 0, 0, 0, '0, '0, 0, '0, '0, '0, 0);
    for (int p = 0; p < 4; p++) run(AW'(p));
    // Stall at pc 4 freezes PC and IF/ID, then resumes.
    for (int i = 0; i < 3; i++) add("stall_hold", 0, 1, 0, '0, 4, 1, 3, 3, 4, 0);
    run(4); run(5);
    // Redirect to 20 at pc 6 costs one bubble.
    add("redirect20", 0, 0, 1, 20, 20, 0, 5, 5, 6, 0);
    run(20);
    // Redirect beats a simultaneous stall.
    add("redir_over_stall", 0, 1, 1, 10, 10, 0, 20, 20, 21, 0);
    for (int p = 10; p < 32; p++) run(AW'(p));
    // pc 32 is out of range: fault, PC held.
    add("fault_enter", 0, 0, 0, '0, 32, 0, 31, 31, 32, 1);
    add("fault_hold", 0, 0, 0, '0, 32, 0, 31, 31, 32, 1);
    add("fault_stall", 0, 1, 0, '0, 32, 0, 31, 31, 32, 1);
    add("fault_redir_oor", 0, 0, 1, 40, 40, 0, 31, 31, 32, 1);
    add("fault_exit", 0, 0, 1, 0, 0, 0, 31, 31, 32, 0);
    for (int p = 0; p < 7; p++) run(AW'(p));
    // Reset coincident with redirect at pc 7: reset wins.
    add("reset_over_redir", 1, 0, 1, 12, '0, 0, '0, '0, '0, 0);
    add("boot_bubble2", 0, 0, 0, '0, '0, 0, '0, '0, '0, 0);
    run(0); run(1);
    // Redirect during the boot bubble.
    add("reset", 1, 0, 0, '0, '0, 0, '0, '0, '0, 0);
    add("boot_redirect", 0, 0, 1, 5, 5, 0, '0, '0, '0, 0);
    run(5);
    // Top-of-range PC faults; in-range redirect recovers.
    add("redir_max", 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5, 5, 6, 0);
    add("fault_max", 0, 0, 0, '0, 32'hFFFF_FFFF, 0, 5, 5, 6, 1);
    add("fault_exit3", 0, 0, 1, 3, 3, 0, 5, 5, 6, 0);
    run(3);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v.rst; stall = v.stl; redirect_valid = v.rv; redirect_pc = v.rpc;
      sb.push_back(v);
      @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL vec %0d scoreboard: got empty queue, required an entry", i);
      end else begin
        e = sb.pop_front();
        if (imem_addr !== e.e_addr || id_valid !== e.e_valid || id_instr !== e.e_instr ||
            id_pc !== e.e_pc || id_pc_next !== e.e_pcn || fetch_fault !== e.e_fault) begin
          n_bad++;
          $display("FAIL vec %0d %s: got addr=%h valid=%b instr=%h pc=%h pcn=%h fault=%b, required addr=%h valid=%b instr=%h pc=%h pcn=%h fault=%b",
                   i, e.name, imem_addr, id_valid, id_instr, id_pc, id_pc_next, fetch_fault,
                   e.e_addr, e.e_valid, e.e_instr, e.e_pc, e.e_pcn, e.e_fault);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
